wb_axi_bridge: RTL and testbench

Parametrised Wishbone classic slave that bridges CPU accesses to one AXI-lite master port and N_CH AXI-stream channel pairs. Each channel pair is one ss (write) master and one sm (read) slave. Intended to front several FIR or accelerator instances in the user project area. Ack and read data are registered. AW and W handshakes are tracked independently, with per-beat tlast generation and capture. A bus-error timeout is optional.

---
 rtl/wb_axi_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_wb_axi_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_axi_bridge.sv
// Wishbone classic slave bridging to one AXI-lite master and N_CH AXI-stream channel pairs.
// Define WB_AXI_TIMEOUT_EN to build the handshake timeout that answers with wbs_err_o.
module wb_axi_bridge #(
  parameter int N_CH    = 2,
  parameter int AXIL_AW = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXIL_AW-1:0]    awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [AXIL_AW-1:0]    araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  output logic [N_CH-1:0]       ss_tvalid,
  output logic [N_CH-1:0]       ss_tlast,
  input  logic [N_CH-1:0]       ss_tready,
  output logic [32*N_CH-1:0]    ss_tdata,
  input  logic [N_CH-1:0]       sm_tvalid,
  input  logic [N_CH-1:0]       sm_tlast,
  output logic [N_CH-1:0]       sm_tready,
  input  logic [32*N_CH-1:0]    sm_tdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LW   = 3'd1;
  localparam logic [2:0] S_LR   = 3'd2;
  localparam logic [2:0] S_SW   = 3'd3;
  localparam logic [2:0] S_SR   = 3'd4;
  localparam logic [2:0] S_STAT = 3'd5;
  localparam logic [2:0] S_ACK  = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  logic [2:0]         state_q, state_d, fin_state;
  logic               aw_done_q, w_done_q, ar_done_q, abort_q, ack_q, last_q;
  logic [AXIL_AW-1:0] addr_q;
  logic [31:0]        wdat_q, dat_q, sel_data;
  logic [3:0]         sel_q;
  logic [2:0]         ch_q, dec_ch;
  logic [N_CH-1:0]    last_flag_q, ch_oh;
  logic               req, busy, dec_ch_ok, sel_last, timeout;
  logic               aw_hs, w_hs, ar_hs, r_hs, ss_hs, sm_hs, part_hs;
  logic               unused_adr;

  assign unused_adr = ^wbs_adr_i[31:AXIL_AW];

  assign req       = wbs_stb_i & wbs_cyc_i;
  assign dec_ch    = wbs_adr_i[6:4];
  assign dec_ch_ok = (int'(dec_ch) < N_CH);
  assign busy      = (state_q == S_LW) || (state_q == S_LR) ||
                     (state_q == S_SW) || (state_q == S_SR);

  always_comb begin
    ch_oh    = '0;
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_oh[k] = (ch_q == 3'(k));
      if (ch_q == 3'(k)) sel_data = sm_tdata[32*k +: 32];
    end
  end

  assign sel_last = |(sm_tlast & ch_oh);

  // Valids and readies are pure decodes of registered state, so reset drops them at once.
  assign awvalid   = (state_q == S_LW) && !aw_done_q;
  assign wvalid    = (state_q == S_LW) && !w_done_q;
  assign arvalid   = (state_q == S_LR) && !ar_done_q;
  assign rready    = (state_q == S_LR) && ar_done_q;
  assign ss_tvalid = (state_q == S_SW) ? ch_oh : '0;
  assign ss_tlast  = (state_q == S_SW && last_q) ? ch_oh : '0;
  assign sm_tready = (state_q == S_SR) ? ch_oh : '0;

  always_comb begin
    ss_tdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (state_q == S_SW && ch_oh[k]) ss_tdata[32*k +: 32] = wdat_q;
    end
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdat_q;
  assign wstrb     = sel_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rready & rvalid;
  assign ss_hs   = |(ss_tvalid & ss_tready);
  assign sm_hs   = |(sm_tready & sm_tvalid);
  assign part_hs = aw_hs | w_hs | ar_hs;

`ifdef WB_AXI_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout   = busy && !part_hs && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign wbs_err_o = err_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state_d == S_ERR);
      if (state_d != state_q || part_hs) cnt_q <= '0;
      else if (busy)                     cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign wbs_err_o = 1'b0;
`endif

  // An abandoned cycle still finishes its AXI handshake but is not acknowledged.
  assign fin_state = (abort_q || !req) ? S_IDLE : S_ACK;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!wbs_adr_i[7])  state_d = wbs_we_i ? S_LW : S_LR;
          else if (!dec_ch_ok) state_d = S_ACK;
          else if (wbs_we_i)   state_d = S_SW;
          else                 state_d = wbs_adr_i[3] ? S_STAT : S_SR;
        end
      end
      S_LW:    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = fin_state;
      S_LR:    if (r_hs)  state_d = fin_state;
      S_SW:    if (ss_hs) state_d = fin_state;
      S_SR:    if (sm_hs) state_d = fin_state;
      S_STAT:  state_d = fin_state;
      default: state_d = S_IDLE;
    endcase
    if (timeout && state_d == state_q) state_d = S_ERR;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= S_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ar_done_q   <= 1'b0;
      abort_q     <= 1'b0;
      ack_q       <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      ch_q        <= '0;
      dat_q       <= '0;
      last_flag_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == S_ACK);
      if (busy && !req) abort_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q    <= wbs_adr_i[AXIL_AW-1:0];
            wdat_q    <= wbs_dat_i;
            sel_q     <= wbs_sel_i;
            ch_q      <= dec_ch;
            last_q    <= wbs_adr_i[3];
            abort_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            if (wbs_adr_i[7] && !dec_ch_ok) dat_q <= '0;
          end
        end
        S_LW: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        S_LR: begin
          if (ar_hs) ar_done_q <= 1'b1;
          if (r_hs)  dat_q     <= rdata;
        end
        S_SR: begin
          if (sm_hs) begin
            dat_q <= sel_data;
            if (sel_last) last_flag_q <= last_flag_q | ch_oh;
          end
        end
        S_STAT: begin
          dat_q       <= {31'b0, |(last_flag_q & ch_oh)};
          last_flag_q <= last_flag_q & ~ch_oh;
        end
        default: ;
      endcase
      if (state_d == S_ERR) dat_q <= 32'hDEAD_BEEF;
    end
  end

endmodule

// File: tb/tb_wb_axi_bridge.sv
// Bench for wb_axi_bridge: vector table, hand sequences for abort/reset/timeout, random accesses vs model.
module tb_wb_axi_bridge;
  localparam int N_CH = 2;
  localparam int AXIL_AW = 12;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 wbs_stb_i = 0, wbs_cyc_i = 0, wbs_we_i = 0;
  logic [3:0]           wbs_sel_i = 0;
  logic [31:0]          wbs_adr_i = 0, wbs_dat_i = 0;
  logic                 wbs_ack_o, wbs_err_o;
  logic [31:0]          wbs_dat_o;
  logic                 awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [AXIL_AW-1:0]   awaddr, araddr;
  logic [31:0]          wdata, rdata;
  logic [3:0]           wstrb;
  logic [N_CH-1:0]      ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tlast, sm_tready;
  logic [32*N_CH-1:0]   ss_tdata, sm_tdata;

  wb_axi_bridge #(.N_CH(N_CH), .AXIL_AW(AXIL_AW), .TIMEOUT(TIMEOUT)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_dat_o(wbs_dat_o), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .ss_tdata(ss_tdata), .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .sm_tdata(sm_tdata)
  );

  // Responders: ready/valid appears once the DUT side has waited *_lat cycles.
  int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, ss_lat = 0, sm_lat = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, ss_cnt = 0, sm_cnt = 0;
  logic [31:0]     r_dat = 0;
  logic [31:0]     sm_dat [N_CH];
  logic [N_CH-1:0] sm_last_cfg = '0;

  always @(posedge clk) begin
    aw_cnt <= awvalid ? aw_cnt + 1 : 0;
    w_cnt  <= wvalid ? w_cnt + 1 : 0;
    ar_cnt <= arvalid ? ar_cnt + 1 : 0;
    r_cnt  <= rready ? r_cnt + 1 : 0;
    ss_cnt <= (|ss_tvalid) ? ss_cnt + 1 : 0;
    sm_cnt <= (|sm_tready) ? sm_cnt + 1 : 0;
  end

  assign awready   = awvalid && (aw_cnt >= aw_lat);
  assign wready    = wvalid && (w_cnt >= w_lat);
  assign arready   = arvalid && (ar_cnt >= ar_lat);
  assign rvalid    = rready && (r_cnt >= r_lat);
  assign rdata     = r_dat;
  assign ss_tready = ss_tvalid & {N_CH{ss_cnt >= ss_lat}};
  assign sm_tvalid = sm_tready & {N_CH{sm_cnt >= sm_lat}};
  assign sm_tlast  = sm_last_cfg;

  always_comb begin
    sm_tdata = '0;
    for (int k = 0; k < N_CH; k++) sm_tdata[32*k +: 32] = sm_dat[k];
  end

  // Monitors of every handshake seen on the AXI side.
  int n_aw = 0, n_w = 0, n_ar = 0, n_ss = 0, n_sm = 0, n_ack = 0, viol = 0, cyc_cnt = 0;
  int aw_cyc = 0, w_cyc = 0, mon_ss_ch = 0;
  logic [AXIL_AW-1:0] mon_awaddr = 0, mon_araddr = 0;
  logic [31:0]        mon_wdata = 0, mon_ss_data = 0;
  logic [3:0]         mon_wstrb = 0;
  logic               mon_ss_last = 0;
  logic [N_CH-1:0]    mon_ss_valid = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (wbs_ack_o) n_ack <= n_ack + 1;
    if (awvalid && awready) begin n_aw <= n_aw + 1; mon_awaddr <= awaddr; aw_cyc <= cyc_cnt; end
    if (wvalid && wready) begin
      n_w <= n_w + 1; mon_wdata <= wdata; mon_wstrb <= wstrb; w_cyc <= cyc_cnt;
    end
    if (arvalid && arready) begin n_ar <= n_ar + 1; mon_araddr <= araddr; end
    if (|(sm_tvalid & sm_tready)) n_sm <= n_sm + 1;
    if (|(ss_tvalid & ss_tready)) begin
      n_ss <= n_ss + 1;
      mon_ss_valid <= ss_tvalid;
      for (int k = 0; k < N_CH; k++) begin
        if (ss_tvalid[k] && ss_tready[k]) begin
          mon_ss_ch <= k; mon_ss_data <= ss_tdata[32*k +: 32]; mon_ss_last <= ss_tlast[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!$onehot0(ss_tvalid) || !$onehot0(sm_tready)) viol <= viol + 1;
  end

  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  int b_aw, b_w, b_ar, b_ss, b_sm;
  task automatic snap();
    b_aw = n_aw; b_w = n_w; b_ar = n_ar; b_ss = n_ss; b_sm = n_sm;
  endtask
  function automatic logic [9:0] ev_delta();
    return {2'(n_aw - b_aw), 2'(n_w - b_w), 2'(n_ar - b_ar), 2'(n_ss - b_ss), 2'(n_sm - b_sm)};
  endfunction

  localparam logic [9:0] EV_W = 10'b01_01_00_00_00;
  localparam logic [9:0] EV_R = 10'b00_00_01_00_00;
  localparam logic [9:0] EV_S = 10'b00_00_00_01_00;
  localparam logic [9:0] EV_M = 10'b00_00_00_00_01;

  // lat: the stb cycle is cycle 1; lat is the cycle in which ack/err is visible.
  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd, output int lat,
                        output logic got_ack, output logic got_err);
    @(negedge clk);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = 1; got_ack = 0; got_err = 0;
    while (!got_ack && !got_err && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      got_ack = wbs_ack_o;
      got_err = wbs_err_o;
    end
    rd = wbs_dat_o;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    @(posedge clk); #1;
    if (got_ack) chk("ack_single_pulse", wbs_ack_o, 1'b0);
    if (got_err) chk("err_single_pulse", wbs_err_o, 1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    int          aw_l, w_l, ar_l, r_l, ss_l, sm_l;
    logic [31:0] cfg;
    logic        cfg_last;
    logic [31:0] exp_rd;
    logic        chk_rd;
    int          exp_lat;
    logic [9:0]  exp_ev;
  } vec_t;

  vec_t vt [11];
  logic [31:0] rd;
  int lat;
  logic ga, ge;
  logic [7:0] mflag;

  initial begin
    vt[0]  = '{1'b1, 32'h3000_0010, 32'h5, 4'hF, 3, 0, 0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 6, EV_W};
    vt[1]  = '{1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, 0, 4, 0, 0, 32'h4, 1'b0, 32'h4, 1'b1, 8, EV_R};
    vt[2]  = '{1'b1, 32'h3000_0098, 32'h7, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 3, EV_S};
    vt[3]  = '{1'b0, 32'h3000_0080, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0, 32'h1234, 1'b1, 32'h1234, 1'b1, 3, EV_M};
    vt[4]  = '{1'b0, 32'h3000_00D0, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0, 32'h55, 1'b1, 32'h0, 1'b1, 2, 10'b0};
    vt[5]  = '{1'b0, 32'h3000_0088, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 32'h1, 1'b1, 3, 10'b0};
    vt[6]  = '{1'b0, 32'h3000_0088, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1, 3, 10'b0};
    vt[7]  = '{1'b1, 32'h3000_00D8, 32'h99, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 2, 10'b0};
    vt[8]  = '{1'b0, 32'h3000_0090, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b1, 5, EV_M};
    vt[9]  = '{1'b0, 32'h3000_0098, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1, 3, 10'b0};
    vt[10] = '{1'b1, 32'h3000_0F7C, 32'hA5A5_5A5A, 4'h3, 0, 2, 0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 5, EV_W};
    for (int k = 0; k < N_CH; k++) sm_dat[k] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_outputs", {wbs_ack_o, wbs_err_o, awvalid, wvalid, arvalid, rready,
                               ss_tvalid, ss_tlast, sm_tready}, '0);
    chk("reset_dat_o", wbs_dat_o, 32'h0);
    chk("reset_ss_tdata", ss_tdata, '0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 11; i++) begin
      aw_lat = vt[i].aw_l; w_lat = vt[i].w_l; ar_lat = vt[i].ar_l;
      r_lat = vt[i].r_l; ss_lat = vt[i].ss_l; sm_lat = vt[i].sm_l;
      r_dat = vt[i].cfg;
      for (int k = 0; k < N_CH; k++) begin
        sm_dat[k]      = (k == int'(vt[i].adr[6:4])) ? vt[i].cfg : ~vt[i].cfg;
        sm_last_cfg[k] = (k == int'(vt[i].adr[6:4])) ? vt[i].cfg_last : 1'b0;
      end
      snap();
      access(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, rd, lat, ga, ge);
      chk($sformatf("vec%0d_ack", i), ga, 1'b1);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_events", i), ev_delta(), vt[i].exp_ev);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      if (i == 0) begin
        chk("lw_awaddr", mon_awaddr, 12'h010);
        chk("lw_wstrb", mon_wstrb, 4'hF);
        chk("lw_wdata", mon_wdata, 32'h5);
        chk("lw_w_before_aw", w_cyc < aw_cyc, 1'b1);
      end
      if (i == 2) begin
        chk("sw_valid_pattern", mon_ss_valid, 2'b10);
        chk("sw_tlast", mon_ss_last, 1'b1);
        chk("sw_tdata", mon_ss_data, 32'h7);
      end
      if (i == 10) begin
        chk("lw2_awaddr", mon_awaddr, 12'hF7C);
        chk("lw2_wstrb", mon_wstrb, 4'h3);
      end
    end

    // Master abandons a stream write: the beat still goes out, no ack follows.
    ss_lat = 6;
    snap();
    begin
      int acks0;
      acks0 = n_ack;
      @(negedge clk);
      wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h3000_0080; wbs_dat_i = 32'hAA;
      repeat (2) @(posedge clk);
      @(negedge clk);
      wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
      repeat (15) @(posedge clk);
      #1;
      chk("abort_beat_done", ev_delta(), EV_S);
      chk("abort_beat_data", mon_ss_data, 32'hAA);
      chk("abort_no_ack", n_ack - acks0, 0);
    end
    ss_lat = 0;

    // Reset mid lite-write: valids drop without waiting for a clock edge.
    aw_lat = 50; w_lat = 50;
    @(negedge clk);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h3000_0020; wbs_dat_i = 32'h1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_valids", {awvalid, wvalid}, 2'b11);
    rst_n = 0;
    #1;
    chk("async_reset_valids", {awvalid, wvalid}, 2'b00);
    @(negedge clk);
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    aw_lat = 0; w_lat = 0;
    @(negedge clk) rst_n = 1;
    r_dat = 32'h600D;
    access(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat, ga, ge);
    chk("post_reset_read_ack", ga, 1'b1);
    chk("post_reset_read_data", rd, 32'h600D);

`ifdef WB_AXI_TIMEOUT_EN
    ss_lat = 100000;
    access(1'b1, 32'h3000_0080, 32'h3, 4'hF, rd, lat, ga, ge);
    chk("timeout_err", {ga, ge}, 2'b01);
    chk("timeout_latency", lat, TIMEOUT + 2);
    chk("timeout_data", rd, 32'hDEAD_BEEF);
    chk("timeout_valid_low", ss_tvalid, '0);
    ss_lat = 0;
    access(1'b0, 32'h3000_0088, 32'h0, 4'hF, rd, lat, ga, ge);
    chk("after_timeout_ack", ga, 1'b1);
`endif

    // Randomized accesses against a transaction-level model.
    mflag = '0;
    for (int i = 0; i < 40; i++) begin
      int kind, ch, lb;
      logic [31:0] adr, dat, exp_rd;
      logic [3:0] sel;
      logic [9:0] exp_ev;
      logic valid, chk_rd;
      kind = $urandom_range(0, 4);
      ch = $urandom_range(0, 3);
      lb = $urandom_range(0, 1);
      dat = $urandom;
      sel = 4'($urandom);
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      ss_lat = $urandom_range(0, 3); sm_lat = $urandom_range(0, 3);
      r_dat = $urandom;
      for (int k = 0; k < N_CH; k++) begin
        sm_dat[k] = $urandom;
        sm_last_cfg[k] = 1'($urandom);
      end
      valid = (ch < N_CH);
      exp_ev = '0; exp_rd = '0; chk_rd = 1'b0;
      case (kind)
        0: begin adr = 32'h3000_0000 | ($urandom & 32'hF7F); exp_ev = EV_W; end
        1: begin adr = 32'h3000_0000 | ($urandom & 32'hF7F); exp_ev = EV_R; exp_rd = r_dat; chk_rd = 1; end
        2: begin
          adr = 32'h3000_0080 | (32'(ch) << 4) | (32'(lb) << 3) | ($urandom & 32'h7);
          if (valid) exp_ev = EV_S;
        end
        3: begin
          adr = 32'h3000_0080 | (32'(ch) << 4) | ($urandom & 32'h7);
          chk_rd = 1;
          if (valid) begin
            exp_ev = EV_M; exp_rd = sm_dat[ch];
            mflag[ch] = mflag[ch] | sm_last_cfg[ch];
          end
        end
        default: begin
          adr = 32'h3000_0088 | (32'(ch) << 4) | ($urandom & 32'h7);
          chk_rd = 1;
          if (valid) begin exp_rd = {31'b0, mflag[ch]}; mflag[ch] = 1'b0; end
        end
      endcase
      snap();
      access(kind == 0 || kind == 2, adr, dat, sel, rd, lat, ga, ge);
      chk($sformatf("rnd%0d_ack", i), ga, 1'b1);
      chk($sformatf("rnd%0d_events", i), ev_delta(), exp_ev);
      if (chk_rd) chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      if (kind == 0) chk($sformatf("rnd%0d_lw", i), {mon_awaddr, mon_wdata, mon_wstrb},
                         {adr[11:0], dat, sel});
      if (kind == 1) chk($sformatf("rnd%0d_araddr", i), mon_araddr, adr[11:0]);
      if (kind == 2 && valid) chk($sformatf("rnd%0d_ss", i),
                                  {mon_ss_ch[2:0], mon_ss_data, mon_ss_last},
                                  {3'(ch), dat, 1'(lb)});
    end

    chk("single_channel_driven", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stalled bench, expected completion");
    $fatal(1, "bench stalled");
  end
endmodule
